// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter sharing one single-beat DRAM port between NUM_REQ requesters,
// with a watchdog that aborts stalled transactions with an error response.
module mem_req_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic [NUM_REQ-1:0]            i_req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
   output logic [NUM_REQ-1:0]            o_rsp_valid,
   output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
   output logic                          o_rsp_err,
   output logic                          o_mem_valid,
   input  logic                          i_mem_ready,
   output logic                          o_mem_we,
   output logic [ADDR_WIDTH-1:0]         o_mem_addr,
   output logic [DATA_WIDTH-1:0]         o_mem_wdata,
   input  logic                          i_mem_rsp,
   input  logic [DATA_WIDTH-1:0]         i_mem_rdata,
   output logic                          o_busy
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

   state_t        state, next;
   logic [GW-1:0] last_grant, grant, win;
   logic [GW:0]   sum;
   logic [CW-1:0] cnt;
   logic          found, accept, done, expire;

   // Scan downward so the candidate closest after last_grant is the one left standing.
   always_comb begin
      win = '0;
      found = 1'b0;
      sum = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         sum = {1'b0, last_grant} + (GW+1)'(i);
         if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
         if (i_req_valid[sum[GW-1:0]]) begin
            win = sum[GW-1:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      next = state;
      o_req_ready = '0;
      accept = 1'b0;
      done = 1'b0;
      expire = 1'b0;
      case (state)
         IDLE: if (found) begin
            o_req_ready[win] = 1'b1;
            accept = 1'b1;
            next = ISSUE;
         end
         ISSUE: if (i_mem_ready) next = WAIT_RSP;
         WAIT_RSP: begin
            done = i_mem_rsp;
            expire = !i_mem_rsp && cnt == CW'(TIMEOUT - 1);
            if (done || expire) next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= GW'(NUM_REQ - 1);
         grant <= '0;
         cnt <= '0;
         o_mem_we <= 1'b0;
         o_mem_addr <= '0;
         o_mem_wdata <= '0;
         o_rsp_valid <= '0;
         o_rsp_rdata <= '0;
         o_rsp_err <= 1'b0;
      end else begin
         if (accept) begin
            grant <= win;
            o_mem_we <= i_req_we[win];
            o_mem_addr <= i_req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            o_mem_wdata <= i_req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
         end
         if (state == ISSUE && i_mem_ready) cnt <= '0;
         else if (state == WAIT_RSP && cnt != '1) cnt <= cnt + 1'b1;
         o_rsp_valid <= (done || expire) ? NUM_REQ'(1) << grant : '0;
         o_rsp_rdata <= (done && !o_mem_we) ? i_mem_rdata : '0;
         o_rsp_err <= expire;
         if (done || expire) last_grant <= grant;
      end
   end

   assign o_mem_valid = state == ISSUE;
   assign o_busy = state != IDLE;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized and directed checks of mem_req_arbiter against a
// round-robin reference model computed from requester masks.
module tb_mem_req_arbiter;
   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0, req_ready, req_we = '0, rsp_valid;
   logic [N*32-1:0] req_addr = '0, req_wdata = '0;
   logic [31:0]   rsp_rdata, mem_addr, mem_wdata, mem_rdata = '0;
   logic          rsp_err, mem_valid, mem_ready = 1'b0, mem_we, mem_rsp = 1'b0, busy;

   int pass_cnt = 0;
   int total = 0;

   mem_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
      .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_we(mem_we),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rsp(mem_rsp), .i_mem_rdata(mem_rdata), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference: first valid requester after the last served one, wrapping around.
   function automatic int rr(input logic [N-1:0] v, input int lg);
      for (int d = 1; d <= N; d++)
         if (v[(lg + d) % N]) return (lg + d) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int k);
      return (k < 0) ? '0 : N'(1 << k);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      mem_ready = 1'b0;
      mem_rsp = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Drives one transaction through the memory side and reports what was observed.
   task automatic serve(input int ml, input int rl, input logic [31:0] rd,
                        output logic [N-1:0] rdy, output logic we, output logic [31:0] a,
                        output logic [31:0] wd, output logic stable, output logic [N-1:0] rv,
                        output logic [31:0] rdo, output logic er);
      int n = 0;
      #1;
      while (req_ready == '0 && n < 20) begin
         step();
         n++;
      end
      rdy = req_ready;
      step();
      we = mem_we;
      a = mem_addr;
      wd = mem_wdata;
      stable = mem_valid;
      for (int i = 0; i < ml; i++) begin
         step();
         stable &= mem_valid && mem_addr == a && mem_wdata == wd && mem_we == we;
      end
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      for (int i = 0; i < rl; i++) step();
      mem_rsp = 1'b1;
      mem_rdata = rd;
      step();
      mem_rsp = 1'b0;
      mem_rdata = $urandom;
      rv = rsp_valid;
      rdo = rsp_rdata;
      er = rsp_err;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if ({req_ready, rsp_valid, mem_valid, busy, rsp_err} !== '0 || mem_addr !== 0 || rsp_rdata !== 0) begin
         $display("FAIL reset_outputs ready=%b rsp=%b mem_valid=%b busy=%b addr=%h required all zero",
                  req_ready, rsp_valid, mem_valid, busy, mem_addr);
      end else pass_cnt++;
      do_reset();
   endtask

   task automatic test_single_read();
      logic [N-1:0] rdy, rv;
      logic we, st, er;
      logic [31:0] a, wd, rdo;
      do_reset();
      req_valid = 3'b001;
      req_we = 3'b000;
      req_addr[0 +: 32] = 32'h100;
      serve(0, 2, 32'hDEADBEEF, rdy, we, a, wd, st, rv, rdo, er);
      req_valid = '0;
      total++;
      if (rdy !== 3'b001) $display("FAIL single_ready got %b want 001", rdy); else pass_cnt++;
      total++;
      if (a !== 32'h100 || we !== 1'b0 || st !== 1'b1) $display("FAIL single_issue addr=%h we=%b valid=%b want 100/0/1", a, we, st); else pass_cnt++;
      total++;
      if (rv !== 3'b001 || rdo !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL single_rsp valid=%b data=%h err=%b want 001/deadbeef/0", rv, rdo, er); else pass_cnt++;
      step();
      total++;
      if (rsp_valid !== '0) $display("FAIL single_pulse_width rsp=%b want 000", rsp_valid); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [N-1:0] rdy, rv;
      logic we, st, er;
      logic [31:0] a, wd, rdo, rd;
      int lg = N - 1;
      int since[N] = '{0, 0, 0};
      do_reset();
      req_valid = 3'b111;
      req_we = 3'b000;
      for (int r = 0; r < N; r++) req_addr[r*32 +: 32] = $urandom;
      for (int t = 0; t < 6; t++) begin
         int k = rr(req_valid, lg);
         rd = $urandom;
         serve($urandom_range(0, 2), $urandom_range(0, 2), rd, rdy, we, a, wd, st, rv, rdo, er);
         total++;
         if (rdy !== oh(k) || rv !== oh(k) || k !== t % N)
            $display("FAIL rr_order txn=%0d ready=%b rsp=%b want %b", t, rdy, rv, oh(t % N));
         else pass_cnt++;
         total++;
         if (a !== req_addr[k*32 +: 32] || rdo !== rd) $display("FAIL rr_data txn=%0d addr=%h data=%h want %h/%h", t, a, rdo, req_addr[k*32 +: 32], rd); else pass_cnt++;
         for (int r = 0; r < N; r++) since[r] = (rv[r] === 1'b1) ? 0 : since[r] + 1;
         total++;
         if (since[0] > 2 || since[1] > 2 || since[2] > 2) $display("FAIL rr_starve txn=%0d waits=%0d,%0d,%0d want <=2", t, since[0], since[1], since[2]); else pass_cnt++;
         lg = k;
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_write_stall();
      logic [N-1:0] rdy, rv;
      logic we, st, er;
      logic [31:0] a, wd, rdo;
      do_reset();
      req_valid = 3'b100;
      req_we = 3'b100;
      req_addr[64 +: 32] = 32'h40;
      req_wdata[64 +: 32] = 32'h12345678;
      serve(5, 1, 32'hFFFF_0000, rdy, we, a, wd, st, rv, rdo, er);
      req_valid = '0;
      req_we = '0;
      total++;
      if (rdy !== 3'b100) $display("FAIL write_ready got %b want 100", rdy); else pass_cnt++;
      total++;
      if (st !== 1'b1 || we !== 1'b1 || a !== 32'h40 || wd !== 32'h12345678)
         $display("FAIL write_stable stable=%b we=%b addr=%h data=%h want 1/1/40/12345678", st, we, a, wd);
      else pass_cnt++;
      total++;
      if (rv !== 3'b100 || rdo !== 0 || er !== 1'b0) $display("FAIL write_rsp valid=%b data=%h err=%b want 100/0/0", rv, rdo, er); else pass_cnt++;
      step();
   endtask

   task automatic test_timeout();
      int c = 0;
      do_reset();
      req_valid = 3'b001;
      req_we = '0;
      step();
      req_valid = '0;
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      while (rsp_valid == '0 && c < 40) begin
         step();
         c++;
      end
      total++;
      if (c !== 16) $display("FAIL timeout_latency got %0d cycles want 16", c); else pass_cnt++;
      total++;
      if (rsp_valid !== 3'b001 || rsp_err !== 1'b1 || rsp_rdata !== 0)
         $display("FAIL timeout_rsp valid=%b err=%b data=%h want 001/1/0", rsp_valid, rsp_err, rsp_rdata);
      else pass_cnt++;
      mem_rsp = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      step();
      mem_rsp = 1'b0;
      total++;
      if (rsp_valid !== '0 || busy !== 1'b0) $display("FAIL late_rsp_ignored rsp=%b busy=%b want 000/0", rsp_valid, busy); else pass_cnt++;
   endtask

   task automatic test_reset_mid_txn();
      do_reset();
      req_valid = 3'b010;
      req_we = '0;
      req_addr[32 +: 32] = 32'h2000;
      step();
      req_valid = '0;
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      step();
      step();
      total++;
      if (busy !== 1'b1 || mem_addr !== 32'h2000) $display("FAIL mid_busy busy=%b addr=%h want 1/2000", busy, mem_addr); else pass_cnt++;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({busy, mem_valid, rsp_valid, req_ready} !== '0 || mem_addr !== 0)
         $display("FAIL async_reset busy=%b mem_valid=%b rsp=%b addr=%h want all zero", busy, mem_valid, rsp_valid, mem_addr);
      else pass_cnt++;
      mem_rsp = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      mem_rsp = 1'b0;
      total++;
      if (rsp_valid !== '0) $display("FAIL reset_no_rsp rsp=%b want 000", rsp_valid); else pass_cnt++;
      req_valid = 3'b111;
      #1;
      total++;
      if (req_ready !== oh(rr(3'b111, N - 1))) $display("FAIL reset_regrant ready=%b want 001", req_ready); else pass_cnt++;
      step();
      req_valid = '0;
      do_reset();
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] rdy, rv;
      logic we, st, er;
      logic [31:0] a, wd, rdo;
      do_reset();
      req_valid = 3'b010;
      req_we = '0;
      serve(0, 0, 32'h11, rdy, we, a, wd, st, rv, rdo, er);
      total++;
      if (rv !== 3'b010) $display("FAIL b2b_first rsp=%b want 010", rv); else pass_cnt++;
      req_valid = 3'b011;
      #1;
      total++;
      if (req_ready !== oh(rr(3'b011, 1)) || rsp_valid !== 3'b010)
         $display("FAIL b2b_grant ready=%b rsp=%b want 001/010", req_ready, rsp_valid);
      else pass_cnt++;
      serve(1, 1, 32'h22, rdy, we, a, wd, st, rv, rdo, er);
      req_valid = '0;
      total++;
      if (rdy !== 3'b001 || rv !== 3'b001 || rdo !== 32'h22) $display("FAIL b2b_second ready=%b rsp=%b data=%h want 001/001/22", rdy, rv, rdo); else pass_cnt++;
      step();
   endtask

   task automatic test_random();
      logic [N-1:0] rdy, rv;
      logic we, st, er;
      logic [31:0] a, wd, rdo, rd;
      int lg = N - 1;
      do_reset();
      for (int t = 0; t < 25; t++) begin
         int k;
         req_valid = N'($urandom_range(1, 7));
         req_we = N'($urandom);
         req_addr = {$urandom, $urandom, $urandom};
         req_wdata = {$urandom, $urandom, $urandom};
         rd = $urandom;
         k = rr(req_valid, lg);
         serve($urandom_range(0, 3), $urandom_range(0, 3), rd, rdy, we, a, wd, st, rv, rdo, er);
         total++;
         if (rdy !== oh(k) || rv !== oh(k)) $display("FAIL rand_grant txn=%0d ready=%b rsp=%b want %b", t, rdy, rv, oh(k)); else pass_cnt++;
         total++;
         if (a !== req_addr[k*32 +: 32] || we !== req_we[k] || wd !== req_wdata[k*32 +: 32] || st !== 1'b1)
            $display("FAIL rand_issue txn=%0d addr=%h we=%b data=%h want %h/%b/%h", t, a, we, wd, req_addr[k*32 +: 32], req_we[k], req_wdata[k*32 +: 32]);
         else pass_cnt++;
         total++;
         if (rdo !== (req_we[k] ? 32'h0 : rd) || er !== 1'b0) $display("FAIL rand_rsp txn=%0d data=%h err=%b want %h/0", t, rdo, er, req_we[k] ? 32'h0 : rd); else pass_cnt++;
         lg = k;
      end
      req_valid = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_stall();
      test_timeout();
      test_reset_mid_txn();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
